// File: rtl/mem_arbiter_if.sv
// Request/grant bus between the two requesters, mem_arbiter and the single-port memory.
// MEM_ARB_PERF_EN adds the arbiter's grant/conflict counters to the slave modport.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_core_gnt;
  logic [31:0]       perf_dbg_gnt;
  logic [31:0]       perf_conflict;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output perf_core_gnt, perf_dbg_gnt, perf_conflict
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  perf_core_gnt, perf_dbg_gnt, perf_conflict
  );
`else
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
`endif
endinterface

// File: rtl/mem_arbiter.sv
// Core/debug arbiter for the unified single-port memory: round-robin with bounded debug lock.
// Define MEM_ARB_PERF_EN to add free-running grant and conflict counters.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned   CntW    = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] LockMax = CntW'(LOCK_MAX);

  typedef enum logic {StRr, StLock} state_e;
  typedef enum logic {OwnCore, OwnDbg} owner_e;

  state_e          state_q, state_d;
  owner_e          last_gnt_q, last_gnt_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic            rd_pend_q, rd_pend_d;
  owner_e          rd_owner_q, rd_owner_d;

  logic            core_win, dbg_win;
  logic            core_gnt, dbg_gnt;
  logic            conflict, lock_full;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign conflict  = bus.core_req & bus.dbg_req;
  assign lock_full = (lock_cnt_q == LockMax);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    core_win   = 1'b0;
    dbg_win    = 1'b0;
    case (state_q)
      StRr: begin
        if (conflict) begin
          core_win = (last_gnt_q == OwnDbg);
          dbg_win  = (last_gnt_q == OwnCore);
        end else begin
          core_win = bus.core_req;
          dbg_win  = bus.dbg_req;
        end
        if (dbg_win && bus.dbg_lock) begin
          state_d    = StLock;
          lock_cnt_d = CntW'(1);
        end
      end
      StLock: begin
        // A full burst yields exactly one grant to a waiting core.
        if (bus.dbg_req && !(lock_full && bus.core_req)) begin
          dbg_win = 1'b1;
        end else begin
          core_win = bus.core_req;
        end
        if (!bus.dbg_req || !bus.dbg_lock || core_win) begin
          state_d    = StRr;
          lock_cnt_d = '0;
        end else if (!lock_full) begin
          lock_cnt_d = lock_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d    = StRr;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Grants are suppressed while reset is held, independent of the request inputs.
  assign core_gnt = core_win & ~reset;
  assign dbg_gnt  = dbg_win & ~reset;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (core_gnt) begin
      last_gnt_d = OwnCore;
    end else if (dbg_gnt) begin
      last_gnt_d = OwnDbg;
    end
  end

  always_comb begin
    rd_pend_d  = (core_gnt & ~bus.core_we) | (dbg_gnt & ~bus.dbg_we);
    rd_owner_d = dbg_gnt ? OwnDbg : OwnCore;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRr;
      last_gnt_q <= OwnDbg;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OwnCore;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_comb begin
    sel_addr  = bus.core_addr;
    sel_wdata = bus.core_wdata;
    if (dbg_gnt) begin
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
    end
  end

  assign bus.mem_addr    = sel_addr;
  assign bus.mem_wdata   = sel_wdata;
  assign bus.mem_we      = (core_gnt & bus.core_we) | (dbg_gnt & bus.dbg_we);

  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.core_rvalid = rd_pend_q & (rd_owner_q == OwnCore);
  assign bus.dbg_rvalid  = rd_pend_q & (rd_owner_q == OwnDbg);
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata   = bus.mem_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_core_q, perf_dbg_q, perf_conf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_core_q <= '0;
      perf_dbg_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_core_q <= perf_core_q + 32'(core_gnt);
      perf_dbg_q  <= perf_dbg_q + 32'(dbg_gnt);
      perf_conf_q <= perf_conf_q + 32'(conflict);
    end
  end

  assign bus.perf_core_gnt = perf_core_q;
  assign bus.perf_dbg_gnt  = perf_dbg_q;
  assign bus.perf_conflict = perf_conf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic vs a reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LOCK_MAX  = 16;
  localparam int unsigned MEM_WORDS = 256;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // Memory with one cycle of read latency.
  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(i);
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, burst length, memory image, pending read return.
  bit          m_locked;
  bit          m_last_dbg;
  int          m_burst;
  bit          m_pend;
  bit          m_pend_dbg;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [MEM_WORDS];

  txn_t c_tx, d_tx;
  bit   d_lock;

  task automatic model_predict(output bit ec, output bit ed);
    ec = 1'b0;
    ed = 1'b0;
    if (m_locked) begin
      if (d_tx.req && !(c_tx.req && m_burst >= int'(LOCK_MAX))) ed = 1'b1;
      else ec = c_tx.req;
    end else if (c_tx.req && d_tx.req) begin
      ec = m_last_dbg;
      ed = !m_last_dbg;
    end else begin
      ec = c_tx.req;
      ed = d_tx.req;
    end
  endtask

  task automatic step(input bit rst_now, output bit got_c, output bit got_d);
    bit   ec, ed;
    txn_t g;
    @(negedge clk);
    reset          = rst_now;
    bus.core_req   = c_tx.req;
    bus.core_we    = c_tx.we;
    bus.core_addr  = c_tx.addr;
    bus.core_wdata = c_tx.wdata;
    bus.dbg_req    = d_tx.req;
    bus.dbg_we     = d_tx.we;
    bus.dbg_addr   = d_tx.addr;
    bus.dbg_wdata  = d_tx.wdata;
    bus.dbg_lock   = d_lock;
    #1;
    if (rst_now) begin
      m_pend = 0; m_locked = 0; m_last_dbg = 1; m_burst = 0;
      ec = 0; ed = 0;
    end else begin
      model_predict(ec, ed);
    end
    check_eq("core_gnt", bus.core_gnt, ec);
    check_eq("dbg_gnt", bus.dbg_gnt, ed);
    check_eq("core_rvalid", bus.core_rvalid, m_pend && !m_pend_dbg);
    check_eq("dbg_rvalid", bus.dbg_rvalid, m_pend && m_pend_dbg);
    if (m_pend && !m_pend_dbg) check_eq("core_rdata", bus.core_rdata, m_pend_data);
    if (m_pend && m_pend_dbg) check_eq("dbg_rdata", bus.dbg_rdata, m_pend_data);
    g = ed ? d_tx : c_tx;
    check_eq("mem_addr", bus.mem_addr, g.addr);
    check_eq("mem_we", bus.mem_we, (ec || ed) && g.we);
    if ((ec || ed) && g.we) check_eq("mem_wdata", bus.mem_wdata, g.wdata);
    // Commit this cycle into the model.
    m_pend = 0;
    if (ec || ed) begin
      if (g.we) ref_mem[g.addr[9:2]] = g.wdata;
      else begin
        m_pend = 1; m_pend_dbg = ed; m_pend_data = ref_mem[g.addr[9:2]];
      end
    end
    if (ec) m_last_dbg = 0;
    if (ed) m_last_dbg = 1;
    if (m_locked) begin
      if (ed && d_lock) m_burst = (m_burst + 1 > int'(LOCK_MAX)) ? int'(LOCK_MAX) : m_burst + 1;
      else m_locked = 0;
    end else if (ed && d_lock) begin
      m_locked = 1;
      m_burst  = 1;
    end
    got_c = bus.core_gnt;
    got_d = bus.dbg_gnt;
  endtask

  task automatic rand_txn(output txn_t t);
    t.req   = 1'b1;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
    t.wdata = $urandom();
  endtask

  task automatic mk_txn(output txn_t t, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    t.req = 1'b1; t.we = we; t.addr = addr; t.wdata = wdata;
  endtask

  initial begin
    bit gc, gd, rst_now;
    int q[$];
    int d_left, i, run;
    c_tx = '0; d_tx = '0; d_lock = 1'b0;
    for (int k = 0; k < MEM_WORDS; k++) ref_mem[k] = init_word(k);
    m_pend = 0; m_locked = 0; m_last_dbg = 1; m_burst = 0;

    step(1, gc, gd);
    step(1, gc, gd);
    mem_init = 1'b0;

    // Both request continuously: strict alternation starting with the core.
    for (int k = 0; k < 8; k++) begin
      if (!c_tx.req) begin rand_txn(c_tx); c_tx.we = 1'b0; end
      if (!d_tx.req) begin rand_txn(d_tx); d_tx.we = 1'b0; end
      step(0, gc, gd);
      check_eq("alt_core", gc, (k % 2) == 0);
      check_eq("alt_dbg", gd, (k % 2) == 1);
      if (gc) c_tx.req = 1'b0;
      if (gd) d_tx.req = 1'b0;
    end
    c_tx.req = 1'b0; d_tx.req = 1'b0;
    step(0, gc, gd);
`ifdef MEM_ARB_PERF_EN
    check_eq("perf_conflict", bus.perf_conflict, 8);
    check_eq("perf_core_gnt", bus.perf_core_gnt, 4);
    check_eq("perf_dbg_gnt", bus.perf_dbg_gnt, 4);
`endif

    // Core-only read of 0x10.
    mk_txn(c_tx, 0, 32'h10, 0);
    step(0, gc, gd);
    check_eq("t1_gnt", gc, 1);
    c_tx.req = 1'b0;
    step(0, gc, gd);
    check_eq("t1_rvalid", bus.core_rvalid, 1);
    check_eq("t1_rdata", bus.core_rdata, 32'hDEADBEEF);
    check_eq("t1_dbg_rvalid", bus.dbg_rvalid, 0);

    // Debug write then core read-back.
    mk_txn(d_tx, 1, 32'h20, 32'hCAFEF00D);
    step(0, gc, gd);
    if (gd) d_tx.req = 1'b0;
    mk_txn(c_tx, 0, 32'h20, 0);
    step(0, gc, gd);
    if (gc) c_tx.req = 1'b0;
    step(0, gc, gd);
    check_eq("t4_rdata", bus.core_rdata, 32'hCAFEF00D);

    // Reset in the cycle after a core read grant drops the return.
    mk_txn(c_tx, 0, 32'h30, 0);
    step(0, gc, gd);
    if (gc) c_tx.req = 1'b0;
    mk_txn(c_tx, 0, 32'h40, 0);
    mk_txn(d_tx, 0, 32'h44, 0);
    step(1, gc, gd);
    check_eq("t5_rvalid", bus.core_rvalid, 0);
    step(1, gc, gd);
    step(0, gc, gd);
    check_eq("t5_first_core", gc, 1);
    if (gc) c_tx.req = 1'b0;

    // Lock taken then dbg_req drops: back to round-robin with last grant DBG.
    d_lock = 1'b1;
    step(0, gc, gd);
    if (gd) d_tx.req = 1'b0;
    step(0, gc, gd);
    mk_txn(c_tx, 0, 32'h50, 0);
    mk_txn(d_tx, 0, 32'h54, 0);
    step(0, gc, gd);
    check_eq("t6_core_wins", gc, 1);
    if (gc) c_tx.req = 1'b0;
    step(0, gc, gd);
    if (gd) d_tx.req = 1'b0;
    d_lock = 1'b0;
    step(0, gc, gd);

    // Long locked debug burst against a constantly requesting core.
    d_left = 21;
    for (int k = 0; k < 100 && d_left > 0; k++) begin
      d_lock = 1'b1;
      if (!d_tx.req) begin
        if (d_left == 21) mk_txn(d_tx, 1, 32'h0, 32'h0000_0013);
        else mk_txn(d_tx, 0, 32'h0, 0);
      end
      if (!c_tx.req) mk_txn(c_tx, 0, 32'($urandom_range(1, MEM_WORDS - 1)) << 2, 0);
      step(0, gc, gd);
      if (gc) begin q.push_back(0); c_tx.req = 1'b0; end
      if (gd) begin q.push_back(1); d_tx.req = 1'b0; d_left--; end
    end
    check_eq("t3_done", d_left, 0);
    i = 0;
    while (i < q.size() && q[i] != 1) i++;
    run = 0;
    while (i < q.size() && q[i] == 1) begin run++; i++; end
    check_eq("t3_burst_len", run, LOCK_MAX);
    check_eq("t3_forced_core", (i < q.size()) ? q[i] : 9, 0);
    check_eq("t3_relock", (i + 1 < q.size()) ? q[i + 1] : 9, 1);
    d_lock = 1'b0;
    c_tx.req = 1'b0;
    step(0, gc, gd);

    // Random traffic with occasional lock bursts and asynchronous resets.
    for (int k = 0; k < 2000; k++) begin
      rst_now = ($urandom_range(0, 199) == 0);
      if (!c_tx.req && $urandom_range(0, 99) < 50) rand_txn(c_tx);
      if (!d_tx.req && $urandom_range(0, 99) < 60) rand_txn(d_tx);
      if ($urandom_range(0, 9) == 0) d_lock = ~d_lock;
      step(rst_now, gc, gd);
      if (gc) c_tx.req = 1'b0;
      if (gd) d_tx.req = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
